// File: rtl/obuf_pkg.sv
// obuf_pkg: shared constants, the FSM state type and the lane-slice helper
// for the obuffer4 output collector and its per-column sub-module.
package obuf_pkg;
   localparam int DW   = 8;          // result lane width
   localparam int NCOL = 4;          // columns, and rows captured per column
   localparam int WW   = DW * NCOL;  // de-skewed column word width
   localparam int CW   = 3;          // per-column capture count width (0..4)

   typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

   // MSB of lane k in the packed array row: col0 sits in the top byte.
   function automatic int lane_msb(input int k);
      return WW - 1 - DW * k;
   endfunction
endpackage

// File: rtl/obuffer_col.sv
// obuffer_col: one column of the collector. Shifts captured lane bytes into
// a 32-bit word (first byte ends in the MSB) and counts captures up to NCOL.
//   CLK, RSTN : clock, synchronous active-low reset
//   CapEN     : lane valid for this column while capture is permitted
//   Clr       : clear the capture count at the end of a tile
//   Lane      : incoming result byte
//   Word      : de-skewed column word
//   Full      : column holds NCOL bytes once this cycle's capture lands
//   Ovf       : valid arrived while the column was already full
module obuffer_col
   import obuf_pkg::*;
(
   input  logic          CLK,
   input  logic          RSTN,
   input  logic          CapEN,
   input  logic          Clr,
   input  logic [DW-1:0] Lane,
   output logic [WW-1:0] Word,
   output logic          Full,
   output logic          Ovf
);
   logic [CW-1:0] r_cnt;
   logic [WW-1:0] r_word;
   logic          w_full_now;

   assign w_full_now = (r_cnt == CW'(NCOL));
   assign Ovf  = CapEN & w_full_now;
   // Look ahead one capture so the top can enter DRAIN on the same edge as
   // the last capture and present the first word one cycle later.
   assign Full = w_full_now | (CapEN & (r_cnt == CW'(NCOL - 1)));
   assign Word = r_word;

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         r_cnt  <= '0;
         r_word <= '0;
      end else if (Clr) begin
         r_cnt  <= '0;
      end else if (CapEN && !w_full_now) begin
         r_word <= {r_word[WW-DW-1:0], Lane};
         r_cnt  <= r_cnt + CW'(1);
      end
   end
endmodule

// File: rtl/obuffer4.sv
// obuffer4: output collector for the 4x4 MAC array. Captures the skewed
// per-column result bytes, de-skews them into one word per column and
// drains the words in column order over a valid/ready handshake.
//   CLK, RSTN  : clock, synchronous active-low reset
//   OROW_i     : result lanes, col0 in [31:24] .. col3 in [7:0]
//   OCOL_VALID : per-column lane valid
//   ODST_i     : destination tag, taken on the first col0 capture of a tile
//   OWord/OCOL/ODST_o/OVALID, OREADY : drain handshake
//   BUSY       : collecting or draining
//   DONE       : one-cycle pulse after the last word handshake
//   ERR        : sticky protocol error (overflow or valid during drain)
module obuffer4
   import obuf_pkg::*;
(
   input  logic            CLK,
   input  logic            RSTN,
   input  logic [WW-1:0]   OROW_i,
   input  logic [NCOL-1:0] OCOL_VALID,
   input  logic [3:0]      ODST_i,
   output logic [WW-1:0]   OWord,
   output logic [1:0]      OCOL,
   output logic [3:0]      ODST_o,
   output logic            OVALID,
   input  logic            OREADY,
   output logic            BUSY,
   output logic            DONE,
   output logic            ERR
);
   state_t          r_state, w_state_nxt;
   logic [WW-1:0]   r_oword;
   logic [1:0]      r_ocol;
   logic [3:0]      r_dst;
   logic            r_ovalid, r_busy, r_done, r_err, r_tag_seen;
   logic [NCOL-1:0] w_cap_en, w_full, w_ovf;
   logic [WW-1:0]   w_word [NCOL];
   logic            w_clr, w_hs, w_cap0;
   logic [DW-1:0]   w_lane0;

   for (genvar k = 0; k < NCOL; k++) begin : g_col
      obuffer_col u_col (
         .CLK   (CLK),
         .RSTN  (RSTN),
         .CapEN (w_cap_en[k]),
         .Clr   (w_clr),
         .Lane  (OROW_i[lane_msb(k) -: DW]),
         .Word  (w_word[k]),
         .Full  (w_full[k]),
         .Ovf   (w_ovf[k])
      );
   end

   assign w_hs    = r_ovalid & OREADY;
   assign w_lane0 = OROW_i[lane_msb(0) -: DW];
   // Column 0 may take its last byte on the DRAIN entry edge when its
   // valid stream had gaps, so the first word is built from the next value.
   assign w_cap0  = w_cap_en[0] & ~w_ovf[0];

   always_comb begin
      w_state_nxt = r_state;
      w_cap_en    = '0;
      w_clr       = 1'b0;
      case (r_state)
         IDLE: begin
            w_cap_en = OCOL_VALID;
            if (|OCOL_VALID) w_state_nxt = COLLECT;
         end
         COLLECT: begin
            w_cap_en = OCOL_VALID;
            if (&w_full) w_state_nxt = DRAIN;
         end
         DRAIN: begin
            if (w_hs && r_ocol == 2'(NCOL - 1)) begin
               w_state_nxt = IDLE;
               w_clr       = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         r_state    <= IDLE;
         r_oword    <= '0;
         r_ocol     <= '0;
         r_dst      <= '0;
         r_ovalid   <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_tag_seen <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt != IDLE);
         r_done  <= 1'b0;
         if ((|w_ovf) || (r_state == DRAIN && (|OCOL_VALID)))
            r_err <= 1'b1;
         // Tag follows the first col0 byte of the tile, wherever it lands.
         if (w_clr)
            r_tag_seen <= 1'b0;
         else if (r_state != DRAIN && OCOL_VALID[0] && !r_tag_seen) begin
            r_dst      <= ODST_i;
            r_tag_seen <= 1'b1;
         end
         if (r_state != DRAIN && w_state_nxt == DRAIN) begin
            r_ovalid <= 1'b1;
            r_ocol   <= '0;
            r_oword  <= w_cap0 ? {w_word[0][WW-DW-1:0], w_lane0} : w_word[0];
         end else if (r_state == DRAIN && w_hs) begin
            if (r_ocol == 2'(NCOL - 1)) begin
               r_ovalid <= 1'b0;
               r_done   <= 1'b1;
            end else begin
               r_ocol  <= r_ocol + 2'd1;
               r_oword <= w_word[r_ocol + 2'd1];
            end
         end
      end
   end

   assign OWord  = r_oword;
   assign OCOL   = r_ocol;
   assign ODST_o = r_dst;
   assign OVALID = r_ovalid;
   assign BUSY   = r_busy;
   assign DONE   = r_done;
   assign ERR    = r_err;
endmodule

// File: tb/tb_obuffer4.sv
module tb_obuffer4;
   import obuf_pkg::*;

   logic        CLK = 1'b0;
   logic        RSTN;
   logic [31:0] OROW_i;
   logic [3:0]  OCOL_VALID;
   logic [3:0]  ODST_i;
   logic [31:0] OWord;
   logic [1:0]  OCOL;
   logic [3:0]  ODST_o;
   logic        OVALID, OREADY, BUSY, DONE, ERR;

   always #5 CLK = ~CLK;

   obuffer4 dut (
      .CLK(CLK), .RSTN(RSTN), .OROW_i(OROW_i), .OCOL_VALID(OCOL_VALID),
      .ODST_i(ODST_i), .OWord(OWord), .OCOL(OCOL), .ODST_o(ODST_o),
      .OVALID(OVALID), .OREADY(OREADY), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
   );

   int         n_checks = 0;
   int         n_err    = 0;
   logic [7:0] tb_b [4][4];   // tb_b[col][row]: byte for column col, row row
   logic       exp_err   = 1'b0;
   logic       pend_done = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic [3:0] v, input logic [31:0] row, input logic [3:0] dst, input logic rdy);
      OCOL_VALID = v; OROW_i = row; ODST_i = dst; OREADY = rdy;
      @(negedge CLK);
   endtask

   task automatic adv();
      @(posedge CLK); #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         cyc(4'h0, 32'h0, 4'h0, 1'b1);
         chk("idle_DONE", 32'(DONE), 32'(pend_done));
         pend_done = 1'b0;
         chk("idle_BUSY", 32'(BUSY), 0);
         chk("idle_OVALID", 32'(OVALID), 0);
         chk("idle_ERR", 32'(ERR), 32'(exp_err));
         adv();
      end
   endtask

   task automatic fill_rand();
      for (int k = 0; k < 4; k++)
         for (int r = 0; r < 4; r++) tb_b[k][r] = 8'($urandom);
   endtask

   // Nominal skewed tile: column k valid in cycles k..k+3 relative to start.
   // mode 0: ready high; 1: ready low in cycles 8..10; 2: random ready.
   task automatic run_tile(input logic [3:0] tag, input int mode, input bit ovf2, input bit drn_pulse);
      logic [31:0] w [4];
      logic [3:0]  v;
      logic [31:0] row;
      logic        rdy, exp_v;
      int          hs;
      bit          fin;
      hs = 0; fin = 0;
      for (int k = 0; k < 4; k++) w[k] = {tb_b[k][0], tb_b[k][1], tb_b[k][2], tb_b[k][3]};
      for (int n = 0; n < 60 && !fin; n++) begin
         v = 4'h0; row = 32'h0;
         for (int k = 0; k < 4; k++)
            if (n >= k && n < k + 4) begin
               v[k] = 1'b1;
               row[31-8*k -: 8] = tb_b[k][n-k];
            end
         if (ovf2 && n == 6)      begin v[2] = 1'b1; row[15:8]  = 8'hEE; end
         if (drn_pulse && n == 8) begin v[0] = 1'b1; row[31:24] = 8'hDD; end
         if (mode == 0)      rdy = 1'b1;
         else if (mode == 1) rdy = !(n >= 8 && n <= 10);
         else                rdy = 1'($urandom_range(0, 1));
         cyc(v, row, (n == 0) ? tag : ~tag, rdy);
         exp_v = (n >= 7) && (hs < 4);
         chk("DONE", 32'(DONE), 32'(pend_done));
         pend_done = 1'b0;
         chk("BUSY", 32'(BUSY), 32'(n >= 1));
         chk("OVALID", 32'(OVALID), 32'(exp_v));
         chk("ERR", 32'(ERR), 32'(exp_err));
         if (exp_v) begin
            chk("OWord", OWord, w[hs]);
            chk("OCOL", 32'(OCOL), 32'(hs));
            chk("ODST_o", 32'(ODST_o), 32'(tag));
         end
         if (ovf2 && n == 6)      exp_err = 1'b1;
         if (drn_pulse && n == 8) exp_err = 1'b1;
         if (exp_v && rdy) begin
            hs++;
            if (hs == 4) begin pend_done = 1'b1; fin = 1; end
         end
         adv();
      end
      chk("tile_finished", 32'(fin), 1);
   endtask

   initial begin
      RSTN = 1'b0; OCOL_VALID = 4'h0; OROW_i = 32'h0; ODST_i = 4'h0; OREADY = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      @(negedge CLK);
      chk("rst_OWord", OWord, 0);
      chk("rst_OCOL", 32'(OCOL), 0);
      chk("rst_ODST", 32'(ODST_o), 0);
      chk("rst_OVALID", 32'(OVALID), 0);
      chk("rst_BUSY", 32'(BUSY), 0);
      chk("rst_DONE", 32'(DONE), 0);
      chk("rst_ERR", 32'(ERR), 0);
      adv();
      RSTN = 1'b1;

      // nominal tile, tag A then 5 on the input, ready high
      for (int k = 0; k < 4; k++)
         for (int r = 0; r < 4; r++) tb_b[k][r] = 8'(8'h10 + 4*k + r);
      run_tile(4'hA, 0, 0, 0);
      // back-to-back tile starting in the DONE cycle, with backpressure at OCOL=1
      fill_rand();
      run_tile(4'h3, 1, 0, 0);
      idle(3);

      // randomized tiles and ready patterns
      for (int i = 0; i < 6; i++) begin
         fill_rand();
         run_tile(4'($urandom), 2, 0, 0);
         if (i % 2 == 1) idle($urandom_range(0, 2));
      end
      idle(2);

      // overflow on column 2, then a valid during drain (chained)
      fill_rand();
      run_tile(4'h6, 0, 1, 0);
      fill_rand();
      run_tile(4'h9, 2, 0, 1);
      idle(2);

      // reset mid-collect abandons the tile
      fill_rand();
      for (int n = 0; n < 4; n++) begin
         logic [3:0]  v;
         logic [31:0] row;
         v = 4'h0; row = 32'h0;
         for (int k = 0; k < 4; k++)
            if (n >= k) begin v[k] = 1'b1; row[31-8*k -: 8] = tb_b[k][n-k]; end
         if (n == 3) RSTN = 1'b0;
         cyc(v, row, 4'hC, 1'b1);
         adv();
      end
      RSTN = 1'b1;
      cyc(4'h0, 32'h0, 4'h0, 1'b1);
      chk("abort_OWord", OWord, 0);
      chk("abort_OCOL", 32'(OCOL), 0);
      chk("abort_ODST", 32'(ODST_o), 0);
      chk("abort_OVALID", 32'(OVALID), 0);
      chk("abort_BUSY", 32'(BUSY), 0);
      chk("abort_DONE", 32'(DONE), 0);
      chk("abort_ERR", 32'(ERR), 0);
      exp_err = 1'b0; pend_done = 1'b0;
      adv();
      idle(12);
      fill_rand();
      run_tile(4'h7, 0, 0, 0);
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
